// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// seven_seg_pkg: shared scanner states, segment constants, polarity helper.
// Revision: 1.0
// ============================================================================
package seven_seg_pkg;

    typedef enum logic [0:0] {
        ST_DEAD  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    function automatic logic to_level(input logic value, input logic active_low);
        return value ^ active_low;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seven_seg.sv
`default_nettype none
// ============================================================================
// hex_to_seven_seg: combinational hex nibble to {g,f,e,d,c,b,a}, active-high.
// Revision: 1.0
// ============================================================================
module hex_to_seven_seg
    import seven_seg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] nibble,
    output logic [6:0]   seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// seven_seg_scanner: multiplexed seven-segment driver with dead-time between
// digits and frame-synchronous display updates. Option: LEADING_ZERO_SUPPRESS_EN
// Revision: 1.0
// ============================================================================
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_CYCLES   = 50000,
    parameter int DEAD_CYCLES    = 2,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic                    i_load,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame
);

    localparam int MAXC = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
    localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic [DW-1:0]         pend_data, disp_data, disp_data_n;
    logic [NUM_DIGITS-1:0] pend_blank, disp_blank, disp_blank_n;
    logic                  pend_valid;
    logic                  boundary, copy;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            nib;
    logic [6:0]            dec_seg, seg_n, seg_lvl;
    logic [NUM_DIGITS-1:0] an_n, an_lvl;

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic zero_above;
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (pend_data[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        boundary = 1'b0;
        case (state)
            ST_DEAD: begin
                if (cnt == CW'(DEAD_CYCLES - 1)) begin
                    state_n = ST_DRIVE;
                    cnt_n   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt == CW'(DIGIT_CYCLES - 1)) begin
                    state_n = ST_DEAD;
                    cnt_n   = '0;
                    if (idx == IW'(NUM_DIGITS - 1)) begin
                        idx_n    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: state_n = ST_DEAD;
        endcase
        copy         = boundary & pend_valid;
        disp_data_n  = copy ? pend_data : disp_data;
        disp_blank_n = copy ? (pend_blank | lz_mask) : disp_blank;
    end

    // Outputs are built from next-state values so anode and segments switch together.
    assign nib = disp_data_n[{idx_n, 2'b00} +: 4];

    hex_to_seven_seg #(.N(4)) u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    assign seg_n = ((state_n == ST_DRIVE) && !disp_blank_n[idx_n]) ? dec_seg : SEG_OFF;
    assign an_n  = (state_n == ST_DRIVE) ? (NUM_DIGITS'(1) << idx_n) : '0;

    for (genvar i = 0; i < 7; i++) begin : g_seg_lvl
        assign seg_lvl[i] = to_level(seg_n[i], SEG_ACTIVE_LOW != 0);
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_an_lvl
        assign an_lvl[i] = to_level(an_n[i], AN_ACTIVE_LOW != 0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_DEAD;
            cnt        <= '0;
            idx        <= '0;
            disp_data  <= '0;
            disp_blank <= '1;
            pend_data  <= '0;
            pend_blank <= '1;
            pend_valid <= 1'b0;
            o_seg      <= SEG_IDLE;
            o_an       <= AN_IDLE;
            o_frame    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            disp_data  <= disp_data_n;
            disp_blank <= disp_blank_n;
            o_seg      <= seg_lvl;
            o_an       <= an_lvl;
            o_frame    <= copy;
            // A load on the boundary cycle keeps valid set for the following frame.
            if (i_load) begin
                pend_data  <= i_data;
                pend_blank <= i_blank;
                pend_valid <= 1'b1;
            end else if (copy) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// tb_seven_seg_scanner: directed frame-by-frame checks of the scanner outputs.
// Revision: 1.0
// ============================================================================
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int checks = 0;
    int errors = 0;

`ifdef LEADING_ZERO_SUPPRESS_EN
    localparam logic [3:0] BLANK_0042 = 4'b1100;
    localparam logic [3:0] BLANK_0000 = 4'b1110;
`else
    localparam logic [3:0] BLANK_0042 = 4'b0000;
    localparam logic [3:0] BLANK_0000 = 4'b0000;
`endif

    seven_seg_scanner #(
        .NUM_DIGITS     (4),
        .DIGIT_CYCLES   (4),
        .DEAD_CYCLES    (1),
        .AN_ACTIVE_LOW  (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (data),
        .i_load  (load),
        .i_blank (blank),
        .o_seg   (seg),
        .o_an    (an),
        .o_frame (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        check({name, " an"},    16'(an),    16'hF);
        check({name, " seg"},   16'(seg),   16'h7F);
        check({name, " frame"}, 16'(frame), 16'h0);
    endtask

    // One scan frame: 4 digits x (4 drive + 1 dead) cycles, with up to two loads.
    task automatic run_frame(input string name, input int nticks,
                             input logic [15:0] fdata, input logic [3:0] fblank,
                             input logic frame_exp,
                             input int lp0, input logic [15:0] ld0, input logic [3:0] lb0,
                             input int lp1, input logic [15:0] ld1, input logic [3:0] lb1);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_frame;
        int         digit;
        for (int p = 0; p < nticks; p++) begin
            if (p == lp0) begin
                load = 1'b1; data = ld0; blank = lb0;
            end else if (p == lp1) begin
                load = 1'b1; data = ld1; blank = lb1;
            end else begin
                load = 1'b0;
            end
            tick();
            digit = p / 5;
            if ((p % 5) < 4) begin
                exp_an  = ~(4'b0001 << digit);
                exp_seg = fblank[digit] ? 7'h7F : ~hex_seg(fdata[digit*4 +: 4]);
            end else begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end
            exp_frame = (p == 19) ? frame_exp : 1'b0;
            check($sformatf("%s p%0d an", name, p),    16'(an),    16'(exp_an));
            check($sformatf("%s p%0d seg", name, p),   16'(seg),   16'(exp_seg));
            check($sformatf("%s p%0d frame", name, p), 16'(frame), 16'(exp_frame));
        end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data = 16'h0; blank = 4'h0;
        tick(); tick(); tick();
        check_reset("reset");
        rst = 1'b0;

        run_frame("idle",   20, 16'h0000, 4'b1111, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("load1",  20, 16'h0000, 4'b1111, 1'b1,  2, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
        run_frame("s1234",  20, 16'h1234, 4'b0000, 1'b1,  7, 16'hABCD, 4'h0, -1, 16'h0, 4'h0);
        run_frame("sABCD",  20, 16'hABCD, 4'b0000, 1'b1,  3, 16'h1111, 4'h0, 10, 16'h2222, 4'h0);
        run_frame("s2222",  20, 16'h2222, 4'b0000, 1'b1,  5, 16'h8888, 4'b0100, -1, 16'h0, 4'h0);
        run_frame("s8888a", 20, 16'h8888, 4'b0100, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("s8888b", 20, 16'h8888, 4'b0100, 1'b1,  4, 16'h0042, 4'h0, 19, 16'h0000, 4'h0);
        run_frame("s0042",  20, 16'h0042, BLANK_0042, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("s0000",  20, 16'h0000, BLANK_0000, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Reset in the middle of digit 2's drive window with a load pending.
        run_frame("pre_rst", 12, 16'h0000, BLANK_0000, 1'b0, 2, 16'h5678, 4'h0, -1, 16'h0, 4'h0);
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        run_frame("postrst", 20, 16'h0000, 4'b1111, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
